plab5_mcore_mem_part_router: RTL and testbench

Request router that sits directly upstream of the four single-ported test-memory partitions. It decodes the target partition from the request address and checks the requester's security level against a per-partition security register. Permitted requests are forwarded to the selected partition; denied requests are answered locally. Responses return to the requester in request order, merged from the four partition response ports and the local deny path.

---
 rtl/plab5_mcore_mem_part_router.sv | 174 +++++++++++++++++
 tb/tb_plab5_mcore_mem_part_router.sv | 326 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/plab5_mcore_mem_part_router.sv
// Routes memory requests to one of four partitions after a per-partition security check, answers denied requests locally,
// and returns all responses in request order. Define PLAB5_MCORE_ROUTER_VIOLATION_CNT_EN to add viol_count/viol_addr outputs.
module plab5_mcore_mem_part_router #(
    parameter int p_opaque_nbits = 8,
    parameter int p_addr_nbits   = 32,
    parameter int p_data_nbits   = 32,
    parameter int p_part_lsb     = 14,
    parameter int p_max_reqs     = 4,
    localparam int c_len_nbits   = $clog2(p_data_nbits / 8),
    localparam int c_req_cn      = 3 + p_opaque_nbits + p_addr_nbits + c_len_nbits,
    localparam int c_resp_cn     = 3 + p_opaque_nbits + 2 + c_len_nbits
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       cfg_wen,
    input  logic [1:0]                 cfg_idx,
    input  logic                       cfg_sec,
    output logic [3:0]                 part_sec,
    input  logic                       req_val,
    output logic                       req_rdy,
    input  logic [c_req_cn-1:0]        req_control,
    input  logic [p_data_nbits-1:0]    req_data,
    input  logic                       req_sec,
    output logic                       resp_val,
    input  logic                       resp_rdy,
    output logic [c_resp_cn-1:0]       resp_control,
    output logic [p_data_nbits-1:0]    resp_data,
    output logic [3:0]                 part_req_val,
    input  logic [3:0]                 part_req_rdy,
    output logic [c_req_cn-1:0]        part_req_control,
    output logic [p_data_nbits-1:0]    part_req_data,
    input  logic [3:0]                 part_resp_val,
    output logic [3:0]                 part_resp_rdy,
    input  logic [4*c_resp_cn-1:0]     part_resp_control,
    input  logic [4*p_data_nbits-1:0]  part_resp_data
`ifdef PLAB5_MCORE_ROUTER_VIOLATION_CNT_EN
    ,
    output logic [15:0]                viol_count,
    output logic [p_addr_nbits-1:0]    viol_addr
`endif
);

    localparam int c_ptr_nbits = $clog2(p_max_reqs);
    localparam int c_ent_nbits = 1 + 2 + 3 + p_opaque_nbits + c_len_nbits;
    localparam logic [c_ptr_nbits:0] c_full = (c_ptr_nbits + 1)'(p_max_reqs);

    localparam logic [2:0] c_type_read  = 3'd0;
    localparam logic [2:0] c_type_write = 3'd1;
    localparam logic [2:0] c_type_init  = 3'd2;
    localparam logic [2:0] c_type_add   = 3'd3;
    localparam logic [2:0] c_type_and   = 3'd4;
    localparam logic [2:0] c_type_or    = 3'd5;

    logic [3:0]             part_sec_reg;
    logic [c_ptr_nbits:0]   count_reg;
    logic [c_ptr_nbits-1:0] wr_ptr_reg;
    logic [c_ptr_nbits-1:0] rd_ptr_reg;
    logic [c_ent_nbits-1:0] fifo_mem [p_max_reqs];

    // Request decode: control layout is {type, opaque, addr, len}
    logic [2:0]                req_type;
    logic [p_opaque_nbits-1:0] req_opaque;
    logic [c_len_nbits-1:0]    req_len;
    logic [1:0]                req_dest;
    logic                      req_allowed;
    logic                      req_denied;
    logic                      fifo_full;
    logic                      fifo_empty;
    logic                      enq;
    logic                      deq;

    assign req_type   = req_control[c_req_cn-1 -: 3];
    assign req_opaque = req_control[c_req_cn-4 -: p_opaque_nbits];
    assign req_len    = req_control[c_len_nbits-1:0];
    assign req_dest   = req_control[c_len_nbits + p_part_lsb +: 2];

    always_comb begin
        req_allowed = 1'b0;
        case (req_type)
            c_type_read:  req_allowed = (req_sec >= part_sec_reg[req_dest]);
            c_type_write,
            c_type_init,
            c_type_add,
            c_type_and,
            c_type_or:    req_allowed = (req_sec == part_sec_reg[req_dest]);
            default:      req_allowed = 1'b0;
        endcase
    end

    assign req_denied = !req_allowed;
    assign fifo_full  = (count_reg == c_full);
    assign fifo_empty = (count_reg == '0);

    // Full blocks acceptance outright, even when the head drains this cycle
    assign req_rdy = reset && !fifo_full && (req_denied || part_req_rdy[req_dest]);
    assign enq     = req_val && req_rdy;

    assign part_req_control = req_control;
    assign part_req_data    = req_data;

    // FIFO head decode: entry layout is {denied, dest, type, opaque, len}
    logic [c_ent_nbits-1:0]    head_ent;
    logic                      head_denied;
    logic [1:0]                head_dest;
    logic [2:0]                head_type;
    logic [p_opaque_nbits-1:0] head_opaque;
    logic [c_len_nbits-1:0]    head_len;

    assign head_ent    = fifo_mem[rd_ptr_reg];
    assign head_denied = head_ent[c_ent_nbits-1];
    assign head_dest   = head_ent[c_ent_nbits-2 -: 2];
    assign head_type   = head_ent[c_ent_nbits-4 -: 3];
    assign head_opaque = head_ent[c_len_nbits +: p_opaque_nbits];
    assign head_len    = head_ent[c_len_nbits-1:0];

    logic [c_resp_cn-1:0]    part_resp_control_arr [4];
    logic [p_data_nbits-1:0] part_resp_data_arr [4];

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_part
            assign part_req_val[gi] = reset && !fifo_full && req_allowed && (req_dest == 2'(gi)) && req_val;
            assign part_resp_rdy[gi] = reset && !fifo_empty && !head_denied && (head_dest == 2'(gi)) && resp_rdy;
            assign part_resp_control_arr[gi] = part_resp_control[gi*c_resp_cn +: c_resp_cn];
            assign part_resp_data_arr[gi]    = part_resp_data[gi*p_data_nbits +: p_data_nbits];
        end
    endgenerate

    assign resp_val     = reset && !fifo_empty && (head_denied || part_resp_val[head_dest]);
    assign resp_control = head_denied ? {head_type, head_opaque, 2'b00, head_len}
                                      : part_resp_control_arr[head_dest];
    assign resp_data    = head_denied ? '0 : part_resp_data_arr[head_dest];
    assign deq          = resp_val && resp_rdy;

    assign part_sec = part_sec_reg;

    always_ff @(posedge clk) begin
        if (!reset) begin
            count_reg    <= '0;
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
            part_sec_reg <= 4'b0000;
        end else begin
            if (enq) wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (deq) rd_ptr_reg <= rd_ptr_reg + 1'b1;
            if (enq && !deq)      count_reg <= count_reg + 1'b1;
            else if (!enq && deq) count_reg <= count_reg - 1'b1;
            if (cfg_wen) part_sec_reg[cfg_idx] <= cfg_sec;
        end
    end

    // Entry storage needs no reset: occupancy alone decides what is valid
    always_ff @(posedge clk) begin
        if (enq) fifo_mem[wr_ptr_reg] <= {req_denied, req_dest, req_type, req_opaque, req_len};
    end

`ifdef PLAB5_MCORE_ROUTER_VIOLATION_CNT_EN
    logic [15:0]             viol_count_reg;
    logic [p_addr_nbits-1:0] viol_addr_reg;

    always_ff @(posedge clk) begin
        if (!reset) begin
            viol_count_reg <= '0;
            viol_addr_reg  <= '0;
        end else if (enq && req_denied) begin
            if (viol_count_reg != 16'hFFFF) viol_count_reg <= viol_count_reg + 16'd1;
            viol_addr_reg <= req_control[c_len_nbits +: p_addr_nbits];
        end
    end

    assign viol_count = viol_count_reg;
    assign viol_addr  = viol_addr_reg;
`endif

endmodule

// File: tb/tb_plab5_mcore_mem_part_router.sv
// Scoreboard bench for plab5_mcore_mem_part_router with behavioural partition models of differing latency.
// Optional violation-counter checks follow PLAB5_MCORE_ROUTER_VIOLATION_CNT_EN.
module tb_plab5_mcore_mem_part_router;

    localparam int O = 8, A = 32, D = 32, LSB = 14, MAXR = 4;
    localparam int LEN = 2;
    localparam int RQC = 3 + O + A + LEN;
    localparam int RSC = 3 + O + 2 + LEN;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            reset;
    logic            cfg_wen;
    logic [1:0]      cfg_idx;
    logic            cfg_sec;
    logic [3:0]      part_sec;
    logic            req_val, req_rdy;
    logic [RQC-1:0]  req_control;
    logic [D-1:0]    req_data;
    logic            req_sec;
    logic            resp_val, resp_rdy;
    logic [RSC-1:0]  resp_control;
    logic [D-1:0]    resp_data;
    logic [3:0]      part_req_val, part_req_rdy;
    logic [RQC-1:0]  part_req_control;
    logic [D-1:0]    part_req_data;
    logic [3:0]      part_resp_val, part_resp_rdy;
    logic [4*RSC-1:0] part_resp_control;
    logic [4*D-1:0]  part_resp_data;
`ifdef PLAB5_MCORE_ROUTER_VIOLATION_CNT_EN
    logic [15:0]     viol_count;
    logic [A-1:0]    viol_addr;
`endif

    plab5_mcore_mem_part_router #(
        .p_opaque_nbits(O), .p_addr_nbits(A), .p_data_nbits(D),
        .p_part_lsb(LSB), .p_max_reqs(MAXR)
    ) dut (
        .clk(clk), .reset(reset),
        .cfg_wen(cfg_wen), .cfg_idx(cfg_idx), .cfg_sec(cfg_sec), .part_sec(part_sec),
        .req_val(req_val), .req_rdy(req_rdy), .req_control(req_control),
        .req_data(req_data), .req_sec(req_sec),
        .resp_val(resp_val), .resp_rdy(resp_rdy), .resp_control(resp_control), .resp_data(resp_data),
        .part_req_val(part_req_val), .part_req_rdy(part_req_rdy),
        .part_req_control(part_req_control), .part_req_data(part_req_data),
        .part_resp_val(part_resp_val), .part_resp_rdy(part_resp_rdy),
        .part_resp_control(part_resp_control), .part_resp_data(part_resp_data)
`ifdef PLAB5_MCORE_ROUTER_VIOLATION_CNT_EN
        , .viol_count(viol_count), .viol_addr(viol_addr)
`endif
    );

    typedef struct packed { logic [RSC-1:0] ctl; logic [D-1:0] data; } exp_t;
    typedef struct packed { logic [RSC-1:0] ctl; logic [D-1:0] data; int ready; } presp_t;

    exp_t         sb [$];
    presp_t       pq [4][$];
    logic [D-1:0] smem [logic [A-1:0]];
    logic [D-1:0] pmem [logic [A+1:0]];
    int           lat [4] = '{1, 2, 2, 6};
    logic [3:0]   msec;
    logic [15:0]  exp_viol;
    logic [A-1:0] exp_vaddr;
    int           cycle = 0;
    int           n_cmp = 0, n_bad = 0;
    logic         last_req_fire, last_resp_fire;
    logic         rand_rdy;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Memory semantics shared by the reference and the partition models
    task automatic mem_op(input logic [2:0] t, input logic [D-1:0] old, input logic [D-1:0] wd,
                          output logic [D-1:0] rd, output logic [D-1:0] nv);
        case (t)
            3'd0:       begin rd = old; nv = old;      end
            3'd1, 3'd2: begin rd = '0;  nv = wd;       end
            3'd3:       begin rd = old; nv = old + wd; end
            3'd4:       begin rd = old; nv = old & wd; end
            3'd5:       begin rd = old; nv = old | wd; end
            default:    begin rd = '0;  nv = old;      end
        endcase
    endtask

    task automatic sb_push(input logic [3:0] pf);
        logic [2:0] t; logic [O-1:0] op; logic [A-1:0] ad; logic [LEN-1:0] ln;
        logic [1:0] dst; logic ok; logic [D-1:0] old, rd, nv; exp_t e;
        {t, op, ad, ln} = req_control;
        dst = ad[LSB +: 2];
        case (t)
            3'd0:                         ok = (req_sec >= msec[dst]);
            3'd1, 3'd2, 3'd3, 3'd4, 3'd5: ok = (req_sec == msec[dst]);
            default:                      ok = 1'b0;
        endcase
        old = smem.exists(ad) ? smem[ad] : '0;
        mem_op(t, old, req_data, rd, nv);
        if (ok) smem[ad] = nv;
        else begin
            if (exp_viol != 16'hFFFF) exp_viol++;
            exp_vaddr = ad;
        end
        e.ctl  = {t, op, 2'b00, ln};
        e.data = ok ? rd : '0;
        sb.push_back(e);
        chk("route", pf, ok ? (4'b0001 << dst) : 4'b0000);
        $display("req  t=%0d opq=%h addr=%h sec=%0d %s", t, op, ad, req_sec, ok ? "fwd" : "deny");
    endtask

    task automatic check_resp();
        exp_t e;
        $display("resp opq=%h data=%h", resp_control[RSC-4 -: O], resp_data);
        if (sb.size() == 0) chk("resp_unexpected", 1, 0);
        else begin
            e = sb.pop_front();
            chk("resp_ctl", resp_control, e.ctl);
            chk("resp_data", resp_data, e.data);
        end
    endtask

    task automatic part_accept(input int i, input logic [RQC-1:0] ctl, input logic [D-1:0] wd);
        logic [2:0] t; logic [O-1:0] op; logic [A-1:0] ad; logic [LEN-1:0] ln;
        logic [A+1:0] key; logic [D-1:0] old, rd, nv; presp_t r;
        {t, op, ad, ln} = ctl;
        key = {2'(i), ad};
        old = pmem.exists(key) ? pmem[key] : '0;
        mem_op(t, old, wd, rd, nv);
        pmem[key] = nv;
        r.ctl = {t, op, 2'b00, ln};
        r.data = rd;
        r.ready = cycle + lat[i] - 1;
        pq[i].push_back(r);
    endtask

    // One clock: sample handshakes at negedge, then advance the partition models after the edge
    task automatic tick();
        logic rq_f, rs_f; logic [3:0] pf, prf; logic [RQC-1:0] pctl; logic [D-1:0] pdat;
        @(negedge clk);
        rq_f = req_val && req_rdy;
        rs_f = resp_val && resp_rdy;
        pf   = part_req_val & part_req_rdy;
        prf  = part_resp_val & part_resp_rdy;
        pctl = part_req_control;
        pdat = part_req_data;
        if (reset) begin
            if (rs_f) check_resp();
            if (rq_f) sb_push(pf);
            else if (pf != 4'b0000) chk("spurious_part_req", pf, 0);
        end
        last_req_fire  = rq_f;
        last_resp_fire = rs_f;
        @(posedge clk);
        #1;
        cycle++;
        if (!reset) begin
            sb.delete();
            for (int i = 0; i < 4; i++) pq[i].delete();
            msec = 4'b0000; exp_viol = '0; exp_vaddr = '0;
        end else begin
            for (int i = 0; i < 4; i++) if (prf[i] && pq[i].size() > 0) pq[i].delete(0);
            for (int i = 0; i < 4; i++) if (pf[i]) part_accept(i, pctl, pdat);
        end
        for (int i = 0; i < 4; i++) begin
            part_resp_val[i] = (pq[i].size() > 0) && (pq[i][0].ready <= cycle);
            part_resp_control[i*RSC +: RSC] = (pq[i].size() > 0) ? pq[i][0].ctl : '0;
            part_resp_data[i*D +: D]        = (pq[i].size() > 0) ? pq[i][0].data : '0;
        end
        if (rand_rdy) begin
            resp_rdy = ($urandom_range(0, 3) != 0);
            for (int i = 0; i < 4; i++) part_req_rdy[i] = ($urandom_range(0, 3) != 0);
        end
    endtask

    task automatic set_req(input logic [2:0] t, input logic [O-1:0] op, input logic [A-1:0] ad,
                           input logic [D-1:0] wd, input logic sec);
        req_control = {t, op, ad, 2'b00};
        req_data    = wd;
        req_sec     = sec;
        req_val     = 1'b1;
    endtask

    task automatic send_req(input logic [2:0] t, input logic [O-1:0] op, input logic [A-1:0] ad,
                            input logic [D-1:0] wd, input logic sec);
        int n = 0;
        set_req(t, op, ad, wd, sec);
        do begin
            tick();
            n++;
        end while (!last_req_fire && n < 200);
        if (!last_req_fire) chk("req_timeout", 0, 1);
        req_val = 1'b0;
    endtask

    task automatic cfg(input logic [1:0] idx, input logic s);
        cfg_wen = 1'b1; cfg_idx = idx; cfg_sec = s;
        tick();
        msec[idx] = s;
        cfg_wen = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() != 0 && n < 500) begin
            tick();
            n++;
        end
        if (sb.size() != 0) chk("drain_timeout", 64'(sb.size()), 0);
    endtask

    initial begin
        reset = 1'b0; cfg_wen = 1'b0; cfg_idx = '0; cfg_sec = 1'b0;
        req_val = 1'b0; req_control = '0; req_data = '0; req_sec = 1'b0;
        resp_rdy = 1'b1; part_req_rdy = 4'hF; part_resp_val = '0;
        part_resp_control = '0; part_resp_data = '0;
        msec = '0; exp_viol = '0; exp_vaddr = '0; rand_rdy = 1'b0;
        last_req_fire = 1'b0; last_resp_fire = 1'b0;

        // Reset state with a request presented
        repeat (3) tick();
        set_req(3'd0, 8'h00, 32'h0, 32'h0, 1'b0);
        #1;
        chk("rst_req_rdy", req_rdy, 0);
        chk("rst_part_req_val", part_req_val, 0);
        chk("rst_resp_val", resp_val, 0);
        chk("rst_part_resp_rdy", part_resp_rdy, 0);
        chk("rst_part_sec", part_sec, 0);
        req_val = 1'b0;
        reset = 1'b1;
        tick();

        // Write then read partition 1
        send_req(3'd1, 8'h11, 32'h0000_4010, 32'hDEAD_BEEF, 1'b0);
        send_req(3'd0, 8'h12, 32'h0000_4010, 32'h0, 1'b0);
        drain();
        chk("p1_mem", pmem.exists({2'd1, 32'h0000_4010}) ? pmem[{2'd1, 32'h0000_4010}] : 32'h0, 32'hDEAD_BEEF);

        // Partition 2 high: low read is denied and answered next cycle
        cfg(2'd2, 1'b1);
        chk("cfg_part_sec", part_sec, msec);
        send_req(3'd0, 8'h21, 32'h0000_8000, 32'h0, 1'b0);
        tick();
        chk("deny_next_cycle", last_resp_fire, 1);
        drain();
`ifdef PLAB5_MCORE_ROUTER_VIOLATION_CNT_EN
        chk("viol_count_1", viol_count, 1);
        chk("viol_addr_1", viol_addr, 32'h0000_8000);
`endif

        // High requester: write to low partition denied, read forwarded
        send_req(3'd1, 8'h31, 32'h0000_0020, 32'h1234_5678, 1'b1);
        send_req(3'd0, 8'h32, 32'h0000_0020, 32'h0, 1'b1);
        drain();

        // Slow partition 3 then fast partition 0: in-order return
        resp_rdy = 1'b0;
        send_req(3'd0, 8'h01, 32'h0000_C000, 32'h0, 1'b0);
        send_req(3'd0, 8'h02, 32'h0000_0000, 32'h0, 1'b0);
        repeat (5) tick();
        resp_rdy = 1'b1;
        drain();

        // Fill the tracking FIFO, then check no same-cycle bypass on dequeue
        resp_rdy = 1'b0;
        for (int k = 0; k < 4; k++) send_req(3'd0, 8'(8'h40 + k), 32'(k * 4), 32'h0, 1'b0);
        repeat (3) tick();
        set_req(3'd0, 8'h44, 32'h0000_0010, 32'h0, 1'b0);
        resp_rdy = 1'b1;
        tick();
        chk("full_no_bypass", last_req_fire, 0);
        chk("full_deq", last_resp_fire, 1);
        tick();
        chk("accept_after_deq", last_req_fire, 1);
        req_val = 1'b0;
        drain();

        // Reset with three outstanding requests
        cfg(2'd1, 1'b1);
        resp_rdy = 1'b0;
        for (int k = 0; k < 3; k++) send_req(3'd0, 8'(8'h50 + k), 32'h0000_C000, 32'h0, 1'b0);
        reset = 1'b0;
        tick();
        chk("midrst_resp_val", resp_val, 0);
        chk("midrst_part_sec", part_sec, 0);
`ifdef PLAB5_MCORE_ROUTER_VIOLATION_CNT_EN
        chk("midrst_viol_count", viol_count, 0);
`endif
        reset = 1'b1;
        resp_rdy = 1'b1;
        tick();
        chk("postrst_resp_val", resp_val, 0);
        send_req(3'd0, 8'h60, 32'h0000_4010, 32'h0, 1'b0);
        drain();

        // Random mixed traffic with random backpressure
        rand_rdy = 1'b1;
        for (int k = 0; k < 60; k++) begin
            logic [2:0] t;
            logic [A-1:0] ad;
            if ($urandom_range(0, 7) == 0) cfg(2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
            case ($urandom_range(0, 6))
                0: t = 3'd0; 1: t = 3'd1; 2: t = 3'd2; 3: t = 3'd3;
                4: t = 3'd4; 5: t = 3'd5; default: t = 3'd7;
            endcase
            ad = {16'h0, 2'($urandom_range(0, 3)), 10'h0, 2'($urandom_range(0, 3)), 2'b00};
            send_req(t, 8'(k), ad, $urandom, 1'($urandom_range(0, 1)));
        end
        rand_rdy = 1'b0;
        resp_rdy = 1'b1;
        part_req_rdy = 4'hF;
        drain();
        chk("final_part_sec", part_sec, msec);
`ifdef PLAB5_MCORE_ROUTER_VIOLATION_CNT_EN
        chk("final_viol_count", viol_count, exp_viol);
        chk("final_viol_addr", viol_addr, exp_vaddr);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
